// File: rtl/sentinel_reg_bank_pkg.sv
// sentinel_reg_bank_pkg
//   Shared constants and helpers for the sentinel register bank.
//   - null_code(width): reserved write code {1'b1, width'b0}; a write carrying it is suppressed.
//   - NullCountW / NullCountMax: width and saturation limit of the suppressed-write counter.
package sentinel_reg_bank_pkg;

    // Widest data width null_code can describe (flag bit included).
    localparam int unsigned NullMaxW = 64;

    localparam int unsigned NullCountW = 8;
    localparam logic [NullCountW-1:0] NullCountMax = 8'hFF;

    // Flag bit set, data bits clear; callers keep the low width+1 bits.
    function automatic logic [NullMaxW-1:0] null_code(input int unsigned width);
        logic [NullMaxW-1:0] code;
        code = '0;
        code[width] = 1'b1;
        return code;
    endfunction

endpackage

// File: rtl/sentinel_reg_bank_if.sv
// sentinel_reg_bank_if
//   Write port, two read ports and status of the sentinel register bank.
//   master: the ALU/operand side driving writes and read addresses.
//   slave : the register bank itself.
//   Signals: enable, wr_addr, D (write), rd_addr_a/b (read addresses),
//            Q_a/Q_b, valid_a/valid_b (read data), null_count, wr_done (status).
interface sentinel_reg_bank_if #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned NUM_REGS = 4
);
    import sentinel_reg_bank_pkg::*;

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic                  enable;
    logic [ADDR_W-1:0]     wr_addr;
    logic [WIDTH:0]        D;
    logic [ADDR_W-1:0]     rd_addr_a;
    logic [ADDR_W-1:0]     rd_addr_b;
    logic [WIDTH-1:0]      Q_a;
    logic [WIDTH-1:0]      Q_b;
    logic                  valid_a;
    logic                  valid_b;
    logic [NullCountW-1:0] null_count;
    logic                  wr_done;

    modport master (
        output enable, wr_addr, D, rd_addr_a, rd_addr_b,
        input  Q_a, Q_b, valid_a, valid_b, null_count, wr_done
    );

    modport slave (
        input  enable, wr_addr, D, rd_addr_a, rd_addr_b,
        output Q_a, Q_b, valid_a, valid_b, null_count, wr_done
    );

endinterface

// File: rtl/sentinel_reg_bank_sat_counter.sv
// sentinel_reg_bank_sat_counter
//   Up-counter that stops at Limit instead of wrapping.
//   Ports: Clock (rising edge), clear (async, active-high), inc (count enable),
//          count (current value).
module sentinel_reg_bank_sat_counter #(
    parameter int unsigned      Width = 8,
    parameter logic [Width-1:0] Limit = '1
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             inc,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != Limit)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sentinel_reg_bank.sv
// sentinel_reg_bank
//   NUM_REGS x WIDTH register bank with per-entry valid flags, one write port and two
//   read ports. Writes carrying the null code are dropped and counted instead.
//   Ports: Clock (rising edge), Reset (async, active-high), bus (sentinel_reg_bank_if.slave).
//   READ_REG=0: combinational reads, no same-cycle bypass.
//   READ_REG=1: registered reads, accepted same-cycle writes bypass to the outputs.
module sentinel_reg_bank
    import sentinel_reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned READ_REG = 0
) (
    input  logic               Clock,
    input  logic               Reset,
    sentinel_reg_bank_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    localparam logic [NullMaxW-1:0] NullFull = null_code(WIDTH);
    localparam logic [WIDTH:0]      NullCode = NullFull[WIDTH:0];

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] valid_q;
    logic                wr_done_q;
    logic                wr_accept;
    logic                wr_null;

    assign wr_accept = bus.enable && (bus.D != NullCode);
    assign wr_null   = bus.enable && (bus.D == NullCode);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            valid_q   <= '0;
            wr_done_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                regs_q[bus.wr_addr]  <= bus.D[WIDTH-1:0];
                valid_q[bus.wr_addr] <= 1'b1;
            end
            wr_done_q <= wr_accept;
        end
    end

    assign bus.wr_done = wr_done_q;

    sentinel_reg_bank_sat_counter #(
        .Width (NullCountW),
        .Limit (NullCountMax)
    ) u_null_count (
        .Clock (Clock),
        .clear (Reset),
        .inc   (wr_null),
        .count (bus.null_count)
    );

    if (READ_REG == 0) begin : g_comb_read
        assign bus.Q_a     = regs_q[bus.rd_addr_a];
        assign bus.Q_b     = regs_q[bus.rd_addr_b];
        assign bus.valid_a = valid_q[bus.rd_addr_a];
        assign bus.valid_b = valid_q[bus.rd_addr_b];
    end else begin : g_reg_read
        logic [WIDTH-1:0] q_a_q, q_b_q;
        logic             valid_a_q, valid_b_q;
        logic             hit_a, hit_b;

        // Write-first: an accepted write to the address being read wins over the old entry.
        assign hit_a = wr_accept && (bus.wr_addr == bus.rd_addr_a);
        assign hit_b = wr_accept && (bus.wr_addr == bus.rd_addr_b);

        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                q_a_q     <= '0;
                q_b_q     <= '0;
                valid_a_q <= 1'b0;
                valid_b_q <= 1'b0;
            end else begin
                q_a_q     <= hit_a ? bus.D[WIDTH-1:0] : regs_q[bus.rd_addr_a];
                q_b_q     <= hit_b ? bus.D[WIDTH-1:0] : regs_q[bus.rd_addr_b];
                valid_a_q <= hit_a | valid_q[bus.rd_addr_a];
                valid_b_q <= hit_b | valid_q[bus.rd_addr_b];
            end
        end

        assign bus.Q_a     = q_a_q;
        assign bus.Q_b     = q_b_q;
        assign bus.valid_a = valid_a_q;
        assign bus.valid_b = valid_b_q;
    end

    logic [ADDR_W-1:0] unused_addr_w;
    assign unused_addr_w = '0;

endmodule

// File: tb/tb_sentinel_reg_bank.sv
// tb_sentinel_reg_bank
//   Two instances (combinational and registered reads) driven with identical directed
//   vectors. Expected outputs are queued with the stimulus and checked at the falling edge.
module tb_sentinel_reg_bank;

    logic Clock;
    logic Reset;

    sentinel_reg_bank_if #(.WIDTH(4), .NUM_REGS(4)) bus0 ();
    sentinel_reg_bank_if #(.WIDTH(4), .NUM_REGS(4)) bus1 ();

    sentinel_reg_bank #(.WIDTH(4), .NUM_REGS(4), .READ_REG(0)) dut0 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus0.slave)
    );

    sentinel_reg_bank #(.WIDTH(4), .NUM_REGS(4), .READ_REG(1)) dut1 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus1.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string      name;
        bit         sel;
        logic [3:0] qa;
        logic       va;
        logic [3:0] qb;
        logic       vb;
        logic [7:0] nc;
        logic       wd;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_out(input string name, input bit sel,
                              input logic [3:0] qa, input logic va,
                              input logic [3:0] qb, input logic vb,
                              input logic [7:0] nc, input logic wd);
        exp_t e;
        e.name = name; e.sel = sel;
        e.qa = qa; e.va = va; e.qb = qb; e.vb = vb; e.nc = nc; e.wd = wd;
        sb.push_back(e);
    endtask

    // Drives the same inputs on both instances just after a rising edge.
    task automatic drive(input logic rst_v, input logic en, input logic [1:0] wa,
                         input logic [4:0] d, input logic [1:0] ra, input logic [1:0] rb);
        @(posedge Clock);
        #1;
        Reset = rst_v;
        bus0.enable = en; bus0.wr_addr = wa; bus0.D = d;
        bus0.rd_addr_a = ra; bus0.rd_addr_b = rb;
        bus1.enable = en; bus1.wr_addr = wa; bus1.D = d;
        bus1.rd_addr_a = ra; bus1.rd_addr_b = rb;
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge Clock) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [3:0] qa, qb;
            logic       va, vb, wd;
            logic [7:0] nc;
            e = sb.pop_front();
            if (e.sel) begin
                qa = bus1.Q_a; va = bus1.valid_a; qb = bus1.Q_b; vb = bus1.valid_b;
                nc = bus1.null_count; wd = bus1.wr_done;
            end else begin
                qa = bus0.Q_a; va = bus0.valid_a; qb = bus0.Q_b; vb = bus0.valid_b;
                nc = bus0.null_count; wd = bus0.wr_done;
            end
            checks++;
            if (qa !== e.qa || va !== e.va || qb !== e.qb || vb !== e.vb ||
                nc !== e.nc || wd !== e.wd) begin
                errors++;
                $display("FAIL %s: got qa=%h va=%b qb=%h vb=%b nc=%h wd=%b, want qa=%h va=%b qb=%h vb=%b nc=%h wd=%b",
                         e.name, qa, va, qb, vb, nc, wd,
                         e.qa, e.va, e.qb, e.vb, e.nc, e.wd);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        bus0.enable = 1'b0; bus0.wr_addr = '0; bus0.D = '0;
        bus0.rd_addr_a = '0; bus0.rd_addr_b = '0;
        bus1.enable = 1'b0; bus1.wr_addr = '0; bus1.D = '0;
        bus1.rd_addr_a = '0; bus1.rd_addr_b = '0;

        // Held in reset with a write pending: everything reads zero.
        drive(1'b1, 1'b1, 2'd2, 5'b00111, 2'd0, 2'd1);
        expect_out("rst_a01_c", 0, 4'h0, 0, 4'h0, 0, 8'h00, 0);
        expect_out("rst_a01_r", 1, 4'h0, 0, 4'h0, 0, 8'h00, 0);
        drive(1'b1, 1'b1, 2'd2, 5'b00111, 2'd2, 2'd3);
        expect_out("rst_a23_c", 0, 4'h0, 0, 4'h0, 0, 8'h00, 0);
        expect_out("rst_a23_r", 1, 4'h0, 0, 4'h0, 0, 8'h00, 0);

        // Release with a write ready: accepted on the first edge after release.
        drive(1'b0, 1'b1, 2'd3, 5'b01010, 2'd3, 2'd0);
        expect_out("post_rst_pending", 0, 4'h0, 0, 4'h0, 0, 8'h00, 0);
        drive(1'b0, 1'b1, 2'd0, 5'b00110, 2'd3, 2'd0);
        expect_out("first_write_c", 0, 4'hA, 1, 4'h0, 0, 8'h00, 1);
        expect_out("first_write_r", 1, 4'hA, 1, 4'h0, 0, 8'h00, 1);

        // Reset asserted mid-cycle with a write pending: outputs clear before any edge.
        drive(1'b0, 1'b1, 2'd1, 5'b01111, 2'd3, 2'd0);
        #2;
        Reset = 1'b1;
        expect_out("midrst_a30_c", 0, 4'h0, 0, 4'h0, 0, 8'h00, 0);
        expect_out("midrst_a30_r", 1, 4'h0, 0, 4'h0, 0, 8'h00, 0);
        drive(1'b1, 1'b1, 2'd1, 5'b01111, 2'd1, 2'd2);
        expect_out("midrst_a12_c", 0, 4'h0, 0, 4'h0, 0, 8'h00, 0);
        expect_out("midrst_a12_r", 1, 4'h0, 0, 4'h0, 0, 8'h00, 0);
        drive(1'b0, 1'b0, 2'd0, 5'b00000, 2'd2, 2'd1);
        expect_out("after_midrst", 0, 4'h0, 0, 4'h0, 0, 8'h00, 0);

        // Basic write/read, no same-cycle visibility with combinational reads.
        drive(1'b0, 1'b1, 2'd2, 5'b00101, 2'd2, 2'd1);
        expect_out("wr_no_bypass", 0, 4'h0, 0, 4'h0, 0, 8'h00, 0);
        drive(1'b0, 1'b0, 2'd2, 5'b00000, 2'd2, 2'd1);
        expect_out("basic_read", 0, 4'h5, 1, 4'h0, 0, 8'h00, 1);

        // Three suppressed writes, then a flagged but non-null write.
        drive(1'b0, 1'b1, 2'd2, 5'b10000, 2'd2, 2'd1);
        expect_out("null_1", 0, 4'h5, 1, 4'h0, 0, 8'h00, 0);
        drive(1'b0, 1'b1, 2'd2, 5'b10000, 2'd2, 2'd1);
        expect_out("null_2", 0, 4'h5, 1, 4'h0, 0, 8'h01, 0);
        drive(1'b0, 1'b1, 2'd2, 5'b10000, 2'd2, 2'd1);
        expect_out("null_3", 0, 4'h5, 1, 4'h0, 0, 8'h02, 0);
        drive(1'b0, 1'b1, 2'd2, 5'b10011, 2'd2, 2'd1);
        expect_out("null_count3", 0, 4'h5, 1, 4'h0, 0, 8'h03, 0);

        // Enable low: neither data nor counter moves.
        drive(1'b0, 1'b0, 2'd2, 5'b10000, 2'd2, 2'd1);
        expect_out("flag_write", 0, 4'h3, 1, 4'h0, 0, 8'h03, 1);
        drive(1'b0, 1'b0, 2'd2, 5'b01111, 2'd2, 2'd1);
        expect_out("en_low_null", 0, 4'h3, 1, 4'h0, 0, 8'h03, 0);
        drive(1'b0, 1'b0, 2'd0, 5'b00000, 2'd2, 2'd1);
        expect_out("en_low_data", 0, 4'h3, 1, 4'h0, 0, 8'h03, 0);

        // Back-to-back accepted writes keep wr_done high.
        drive(1'b0, 1'b1, 2'd0, 5'b00001, 2'd0, 2'd1);
        expect_out("b2b_0", 0, 4'h0, 0, 4'h0, 0, 8'h03, 0);
        drive(1'b0, 1'b1, 2'd1, 5'b00010, 2'd0, 2'd1);
        expect_out("b2b_1", 0, 4'h1, 1, 4'h0, 0, 8'h03, 1);
        drive(1'b0, 1'b1, 2'd3, 5'b10111, 2'd0, 2'd1);
        expect_out("b2b_2", 0, 4'h1, 1, 4'h2, 1, 8'h03, 1);
        drive(1'b0, 1'b0, 2'd0, 5'b00000, 2'd3, 2'd2);
        expect_out("b2b_tail", 0, 4'h7, 1, 4'h3, 1, 8'h03, 1);
        drive(1'b0, 1'b0, 2'd0, 5'b00000, 2'd3, 2'd2);
        expect_out("b2b_done", 0, 4'h7, 1, 4'h3, 1, 8'h03, 0);

        // Saturation: 300 suppressed writes in total.
        for (int i = 0; i < 197; i++) drive(1'b0, 1'b1, 2'd0, 5'b10000, 2'd3, 2'd2);
        drive(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 2'd1);
        expect_out("count_200", 0, 4'h1, 1, 4'h2, 1, 8'hC8, 0);
        for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 2'd0, 5'b10000, 2'd3, 2'd2);
        drive(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 2'd1);
        expect_out("count_sat", 0, 4'h1, 1, 4'h2, 1, 8'hFF, 0);

        // Registered-read bypass: accepted write bypasses, null write does not.
        drive(1'b0, 1'b0, 2'd0, 5'b00000, 2'd1, 2'd1);
        expect_out("pre_bypass_c", 0, 4'h2, 1, 4'h2, 1, 8'hFF, 0);
        drive(1'b0, 1'b1, 2'd1, 5'b01001, 2'd1, 2'd1);
        expect_out("bypass_wr_c", 0, 4'h2, 1, 4'h2, 1, 8'hFF, 0);
        expect_out("bypass_old_r", 1, 4'h2, 1, 4'h2, 1, 8'hFF, 0);
        drive(1'b0, 1'b1, 2'd1, 5'b10000, 2'd1, 2'd1);
        expect_out("bypass_new_r", 1, 4'h9, 1, 4'h9, 1, 8'hFF, 1);
        expect_out("bypass_new_c", 0, 4'h9, 1, 4'h9, 1, 8'hFF, 1);
        drive(1'b0, 1'b0, 2'd0, 5'b00000, 2'd1, 2'd1);
        expect_out("null_no_bypass_r", 1, 4'h9, 1, 4'h9, 1, 8'hFF, 0);
        expect_out("null_hold_c", 0, 4'h9, 1, 4'h9, 1, 8'hFF, 0);

        @(negedge Clock);
        @(posedge Clock);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sentinel_reg_bank.md
Name: sentinel_reg_bank

Overview:
Parametrised successor to the processor's single enable-gated D register. Holds NUM_REGS registers of WIDTH bits, each with a per-entry valid flag, behind one write port and two read ports. Uses the same sentinel rule as the existing register: a write whose data equals the reserved null code is suppressed. Sits between the ALU result bus and the operand-select logic of the microprocessor.

Parameters:
WIDTH, 4, data bits per register; the write bus is WIDTH+1 bits.
NUM_REGS, 4, number of registers; a power of two, minimum 2.
ADDR_W, $clog2(NUM_REGS), address width; derived, not overridden.
READ_REG, 0, 0 = combinational reads; 1 = registered reads with 1-cycle latency and write-first bypass.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
enable  input  1  write request
wr_addr  input  ADDR_W  write target
D  input  WIDTH+1  write data; D[WIDTH] is the null/flag bit
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
Q_a  output  WIDTH  read data A
Q_b  output  WIDTH  read data B
valid_a  output  1  entry at A has been written since reset
valid_b  output  1  entry at B has been written since reset
null_count  output  8  saturating count of suppressed writes
wr_done  output  1  registered pulse: a write was accepted on the previous edge

Behaviour:
- Null code: NULL = {1'b1, WIDTH'b0}, i.e. 5'b10000 at the default width.
- Accepted write: enable=1 and D != NULL at a rising edge. Then reg[wr_addr] <= D[WIDTH-1:0] and valid[wr_addr] <= 1.
- D[WIDTH]=1 with nonzero low bits is an ordinary write; only the low WIDTH bits are stored.
- Suppressed write: enable=1 and D == NULL. Registers and valid flags hold; null_count increments, saturating at 8'hFF and never wrapping.
- enable=0: everything holds; null_count is unchanged regardless of D.
- wr_done: 1 for exactly the cycle after an accepted write, otherwise 0. Back-to-back accepted writes keep it high continuously.
- Reset asserted (asynchronous, any time, including mid-write): all regs become 0, all valid flags 0, null_count 0, wr_done 0. If READ_REG=1, the Q/valid output registers also become 0.
- While Reset is high, writes are ignored. The first write can be accepted at the first rising edge after Reset deasserts.
- READ_REG=0:
  - Q_x = reg[rd_addr_x] and valid_x = valid[rd_addr_x], combinationally.
  - A write becomes visible after the edge that performs it; there is no same-cycle bypass.
- READ_REG=1:
  - Q_x and valid_x are registered on each edge from the addresses presented in that cycle.
  - If an accepted write targets rd_addr_x in the same cycle, the registered output takes the new data and valid=1 (write-first).
  - A suppressed write never bypasses.
- Both read ports may address the same entry, and either may equal wr_addr; no port conflicts exist.
- Addresses are always in range (NUM_REGS is a power of two), so no out-of-range case arises.

Decomposition:
- Shared package: NULL code function of WIDTH, the null_count width constant (8), and the saturation limit constant.
- One natural sub-module, sat_counter (parametrised width; increment enable; asynchronous active-high clear), used for null_count.
- Storage, valid flags and the read path stay in the top module, inside a generate block on READ_REG.

Test Plan:
- Reset then read: assert Reset mid-cycle with writes pending, then read all addresses -> Q=0, valid=0, null_count=0, wr_done=0 immediately, without waiting for a clock edge.
- Basic write/read (READ_REG=0): write D=5'b00101 to addr 2, then read A=2, B=1 -> Q_a=4'h5, valid_a=1, Q_b=0, valid_b=0; wr_done=1 for one cycle.
- Sentinel suppression: after the above, write D=5'b10000 to addr 2 three times -> Q_a stays 4'h5, null_count=3, wr_done=0. Then write D=5'b10011 -> Q_a=4'h3.
- Enable low: enable=0 with D=5'b10000 and D=5'b01111 -> no change to any register or to null_count.
- Saturation: 300 suppressed writes -> null_count=8'hFF, not wrapping to 8'h2C.
- Bypass (READ_REG=1): same cycle write D=5'b01001 to addr 1 with rd_addr_a=1 and rd_addr_b=1 -> after the edge Q_a=Q_b=4'h9, valid=1. Repeat with D=NULL -> outputs hold their old contents.
